// File: rtl/sid_bus_pkg.sv
// Shared types and SID register map for the SID bus player.
// The command struct is sized for the default delay width; the player builds the same layout for its own DLY_W.
package sid_bus_pkg;

  localparam int SID_DLY_W = 16;

  localparam logic [4:0] SID_POTX    = 5'h19;
  localparam logic [4:0] SID_POTY    = 5'h1A;
  localparam logic [4:0] SID_OSC3    = 5'h1B;
  localparam logic [4:0] SID_ENV3    = 5'h1C;
  localparam logic [4:0] SID_LAST_WR = 5'h18;

  typedef struct packed {
    logic                 rd;
    logic [4:0]           addr;
    logic [7:0]           wdata;
    logic [SID_DLY_W-1:0] delay;
  } sid_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2
  } sid_state_e;

endpackage

// File: rtl/sid_cmd_fifo.sv
// Generic synchronous FIFO with sync reset and flush; DEPTH must be a power of two.
// Handshake: an entry is written when push && ready; flush wins over both push and pop.
module sid_cmd_fifo #(
  parameter int  DEPTH = 16,
  parameter type T     = logic [7:0]
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  T                       push_data,
  output logic                   ready,
  input  logic                   pop,
  output T                       head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign ready   = (level != FULL_LEVEL);
  assign empty   = (level == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && ready && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sid_bus_player.sv
// Replays queued, ce_1m-paced register accesses onto the SID bus.
// Optional SID_PLAYER_SHADOW_EN adds a write shadow so reads of write-only registers return the last written value.
module sid_bus_player
  import sid_bus_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DLY_W = SID_DLY_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ce_1m,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_rd,
  input  logic [4:0]             cmd_addr,
  input  logic [7:0]             cmd_wdata,
  input  logic [DLY_W-1:0]       cmd_delay,
  input  logic                   flush,
  output logic                   sid_we,
  output logic [4:0]             sid_addr,
  output logic [7:0]             sid_wdata,
  input  logic [7:0]             sid_rdata,
  output logic                   rd_valid,
  output logic [7:0]             rd_data,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
`ifdef SID_PLAYER_SHADOW_EN
  input  logic [4:0]             shadow_addr,
  output logic [7:0]             shadow_q,
`endif
  output sid_state_e             fsm_state
);

  typedef struct packed {
    logic             rd;
    logic [4:0]       addr;
    logic [7:0]       wdata;
    logic [DLY_W-1:0] delay;
  } cmd_t;

  cmd_t             in_cmd;
  cmd_t             head;
  logic             fifo_empty;
  logic             pop;
  sid_state_e       state;
  sid_state_e       state_nxt;
  logic [DLY_W-1:0] cnt;
  logic             issue_now;
  logic             cur_rd;
  logic [4:0]       cur_addr;
  logic [7:0]       cur_wdata;
  logic [4:0]       addr_q;
  logic [7:0]       wdata_q;
  logic [7:0]       rd_sample;

  always_comb begin
    in_cmd       = '0;
    in_cmd.rd    = cmd_rd;
    in_cmd.addr  = cmd_addr;
    in_cmd.wdata = cmd_wdata;
    in_cmd.delay = cmd_delay;
  end

  sid_cmd_fifo #(
    .DEPTH (DEPTH),
    .T     (cmd_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (cmd_valid),
    .push_data (in_cmd),
    .ready     (cmd_ready),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .level     (level)
  );

  // The pop clk never counts as a tick: WAIT/ISSUE only react to ce_1m from the following clk on.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    issue_now = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !flush) begin
          pop       = 1'b1;
          state_nxt = (head.delay != '0) ? WAIT : ISSUE;
        end
      end
      WAIT: begin
        if (ce_1m && cnt == DLY_W'(1)) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (ce_1m) begin
          issue_now = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cur_rd    <= 1'b0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      state    <= state_nxt;
      rd_valid <= issue_now && cur_rd;
      if (pop) begin
        cur_rd    <= head.rd;
        cur_addr  <= head.addr;
        cur_wdata <= head.wdata;
      end
      if (flush)                    cnt <= '0;
      else if (pop)                 cnt <= head.delay;
      else if (state == WAIT && ce_1m) cnt <= cnt - 1'b1;
      if (issue_now) begin
        addr_q <= cur_addr;
        if (cur_rd) rd_data <= rd_sample;
        else        wdata_q <= cur_wdata;
      end
    end
  end

  // Address/data are driven live on the access clk and held from registers otherwise.
  assign sid_we    = issue_now && !cur_rd;
  assign sid_addr  = issue_now ? cur_addr : addr_q;
  assign sid_wdata = (issue_now && !cur_rd) ? cur_wdata : wdata_q;
  assign busy      = !fifo_empty || (state != IDLE);
  assign fsm_state = state;

`ifdef SID_PLAYER_SHADOW_EN
  logic [7:0] shadow [25];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 25; i++) shadow[i] <= '0;
    end else if (issue_now && !cur_rd && cur_addr <= SID_LAST_WR) begin
      shadow[cur_addr] <= cur_wdata;
    end
  end

  assign rd_sample = (cur_addr <= SID_LAST_WR) ? shadow[cur_addr] : sid_rdata;
  assign shadow_q  = (shadow_addr <= SID_LAST_WR) ? shadow[shadow_addr] : 8'h00;
`else
  assign rd_sample = sid_rdata;
`endif

endmodule

// File: tb/tb_sid_bus_player.sv
// Directed bench for sid_bus_player with a tiny SID register model on the bus.
// Honours SID_PLAYER_SHADOW_EN for the extra ports and the shadow read-back case.
module tb_sid_bus_player;
  import sid_bus_pkg::*;

  localparam int DEPTH  = 16;
  localparam int DLY_W  = 16;
  localparam int CE_DIV = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             ce_1m = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_rd = 1'b0;
  logic [4:0]       cmd_addr = '0;
  logic [7:0]       cmd_wdata = '0;
  logic [DLY_W-1:0] cmd_delay = '0;
  logic             flush = 1'b0;
  logic             cmd_ready;
  logic             sid_we;
  logic [4:0]       sid_addr;
  logic [7:0]       sid_wdata;
  logic [7:0]       sid_rdata;
  logic             rd_valid;
  logic [7:0]       rd_data;
  logic             busy;
  logic [4:0]       level;
  sid_state_e       fsm_state;
`ifdef SID_PLAYER_SHADOW_EN
  logic [4:0]       shadow_addr = '0;
  logic [7:0]       shadow_q;
`endif

  int n_cmp = 0;
  int n_err = 0;

  sid_bus_player #(.DEPTH(DEPTH), .DLY_W(DLY_W)) dut (
    .clk(clk), .reset(reset), .ce_1m(ce_1m), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rd(cmd_rd), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_delay(cmd_delay),
    .flush(flush), .sid_we(sid_we), .sid_addr(sid_addr), .sid_wdata(sid_wdata),
    .sid_rdata(sid_rdata), .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .level(level),
`ifdef SID_PLAYER_SHADOW_EN
    .shadow_addr(shadow_addr), .shadow_q(shadow_q),
`endif
    .fsm_state(fsm_state)
  );

  // clock / 1 MHz enable
  always #5 clk = ~clk;

  int ce_div = 0;
  always @(posedge clk) begin
    ce_div <= (ce_div == CE_DIV-1) ? 0 : ce_div + 1;
    ce_1m  <= (ce_div == CE_DIV-1);
  end

  // SID register model: writes land on ce_1m, pot_x/env3 readable, everything else reads 0
  logic [7:0] sid_regs [32];
  logic [7:0] pot_x = 8'h00;
  always @(posedge clk) if (ce_1m && sid_we) sid_regs[sid_addr] <= sid_wdata;
  assign sid_rdata = (sid_addr == SID_POTX) ? pot_x : (sid_addr == SID_ENV3) ? 8'h5A : 8'h00;

  // bus monitor, sampled on the falling edge
  int tick_cnt = 0, cyc = 0, we_cnt = 0, we_tick = 0, we_no_ce = 0;
  int rd_cnt = 0, rd_tick = 0, rd_cyc = 0, ce_cyc = 0;
  logic [4:0] we_addr = '0, ce_addr = '0;
  logic [7:0] we_data = '0, rd_val = '0;
  always @(negedge clk) begin
    cyc++;
    if (ce_1m) begin tick_cnt++; ce_cyc = cyc; ce_addr = sid_addr; end
    if (sid_we) begin
      we_cnt++; we_tick = tick_cnt; we_addr = sid_addr; we_data = sid_wdata;
      if (!ce_1m) we_no_ce++;
    end
    if (rd_valid) begin rd_cnt++; rd_cyc = cyc; rd_tick = tick_cnt; rd_val = rd_data; end
  end

  // driver tasks; called at posedge+#1, return at posedge+#1
  task automatic push_cmd(input logic rd, input logic [4:0] a, input logic [7:0] d,
                          input int dly, output bit acc);
    cmd_valid = 1'b1; cmd_rd = rd; cmd_addr = a; cmd_wdata = d; cmd_delay = dly[DLY_W-1:0];
    @(negedge clk);
    acc = cmd_ready;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_we(input int target, input int budget, output bit ok);
    int n = 0;
    while (we_cnt < target && n < budget) begin @(posedge clk); #1; n++; end
    ok = (we_cnt >= target);
  endtask

  task automatic wait_rd(input int target, input int budget, output bit ok);
    int n = 0;
    while (rd_cnt < target && n < budget) begin @(posedge clk); #1; n++; end
    ok = (rd_cnt >= target);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (sid_we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b required 0", sid_we); end
      n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b required 1", cmd_ready); end
      n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL reset_level: got %0d required 0", level); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", busy); end
    end
    n_cmp++; if (sid_addr !== 5'h00) begin n_err++; $display("FAIL reset_addr: got %h required 00", sid_addr); end
    n_cmp++; if (sid_wdata !== 8'h00) begin n_err++; $display("FAIL reset_wdata: got %h required 00", sid_wdata); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %b required 0", rd_valid); end
    n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL reset_rd_data: got %h required 00", rd_data); end
    n_cmp++; if (fsm_state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d required %0d", fsm_state, IDLE); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_single_write();
    int we0, base; bit acc, ok;
    we0 = we_cnt;
    push_cmd(1'b0, 5'h18, 8'h0F, 0, acc);
    n_cmp++; if (acc !== 1'b1) begin n_err++; $display("FAIL wr_accept: got %b required 1", acc); end
    @(posedge clk); #1;
    base = tick_cnt;
    wait_we(we0 + 1, 3*CE_DIV, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL wr_timeout: got %0d pulses required %0d", we_cnt - we0, 1); end
    n_cmp++; if (we_tick !== base + 1) begin n_err++; $display("FAIL wr_tick: got %0d required %0d", we_tick, base + 1); end
    n_cmp++; if (we_addr !== 5'h18) begin n_err++; $display("FAIL wr_addr: got %h required 18", we_addr); end
    n_cmp++; if (we_data !== 8'h0F) begin n_err++; $display("FAIL wr_data: got %h required 0f", we_data); end
    repeat (2*CE_DIV) @(posedge clk);
    #1;
    n_cmp++; if (we_cnt !== we0 + 1) begin n_err++; $display("FAIL wr_pulse_count: got %0d required %0d", we_cnt - we0, 1); end
    n_cmp++; if (we_no_ce !== 0) begin n_err++; $display("FAIL wr_we_off_tick: got %0d required 0", we_no_ce); end
    n_cmp++; if (sid_regs[5'h18] !== 8'h0F) begin n_err++; $display("FAIL wr_sid_volume: got %h required 0f", sid_regs[5'h18]); end
    n_cmp++; if (sid_addr !== 5'h18 || sid_wdata !== 8'h0F) begin n_err++; $display("FAIL wr_bus_hold: got %h/%h required 18/0f", sid_addr, sid_wdata); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL wr_busy_after: got %b required 0", busy); end
  endtask

  task automatic test_delay_pacing();
    int we0, base, t1; bit acc1, acc2, ok;
    we0 = we_cnt;
    push_cmd(1'b0, 5'h01, 8'h11, 3, acc1);
    push_cmd(1'b0, 5'h02, 8'h22, 0, acc2);
    base = tick_cnt;   // includes the pop clk of the first command
    n_cmp++; if (!(acc1 && acc2)) begin n_err++; $display("FAIL dly_accept: got %b%b required 11", acc1, acc2); end
    wait_we(we0 + 1, 6*CE_DIV, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL dly_first_timeout: got %0d pulses required 1", we_cnt - we0); end
    n_cmp++; if (we_tick !== base + 4) begin n_err++; $display("FAIL dly_first_tick: got %0d required %0d", we_tick, base + 4); end
    n_cmp++; if (we_addr !== 5'h01 || we_data !== 8'h11) begin n_err++; $display("FAIL dly_first_bus: got %h/%h required 01/11", we_addr, we_data); end
    t1 = we_tick;
    wait_we(we0 + 2, 3*CE_DIV, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL dly_second_timeout: got %0d pulses required 2", we_cnt - we0); end
    n_cmp++; if (we_tick !== t1 + 1) begin n_err++; $display("FAIL dly_second_tick: got %0d required %0d", we_tick, t1 + 1); end
    n_cmp++; if (we_addr !== 5'h02 || we_data !== 8'h22) begin n_err++; $display("FAIL dly_second_bus: got %h/%h required 02/22", we_addr, we_data); end
  endtask

  task automatic test_read(input logic [4:0] a, input logic [7:0] expv, input string name);
    int rd0, we0, base; bit acc, ok;
    rd0 = rd_cnt; we0 = we_cnt;
    push_cmd(1'b1, a, 8'hFF, 0, acc);
    @(posedge clk); #1;
    base = tick_cnt;
    wait_rd(rd0 + 1, 3*CE_DIV, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL %s_timeout: got %0d pulses required 1", name, rd_cnt - rd0); end
    n_cmp++; if (rd_val !== expv) begin n_err++; $display("FAIL %s_data: got %h required %h", name, rd_val, expv); end
    n_cmp++; if (rd_tick !== base + 1) begin n_err++; $display("FAIL %s_tick: got %0d required %0d", name, rd_tick, base + 1); end
    n_cmp++; if (rd_cyc !== ce_cyc + 1) begin n_err++; $display("FAIL %s_latency: got %0d required %0d", name, rd_cyc - ce_cyc, 1); end
    n_cmp++; if (ce_addr !== a) begin n_err++; $display("FAIL %s_addr: got %h required %h", name, ce_addr, a); end
    repeat (2*CE_DIV) @(posedge clk);
    #1;
    n_cmp++; if (rd_cnt !== rd0 + 1) begin n_err++; $display("FAIL %s_pulse_count: got %0d required 1", name, rd_cnt - rd0); end
    n_cmp++; if (we_cnt !== we0) begin n_err++; $display("FAIL %s_no_write: got %0d required 0", name, we_cnt - we0); end
  endtask

  task automatic test_full_flush();
    int we0, n; bit acc;
    we0 = we_cnt; n = 0; acc = 1'b1;
    while (acc && n < DEPTH + 4) begin
      push_cmd(1'b0, 5'(n), 8'(n), 100, acc);
      if (acc) n++;
    end
    n_cmp++; if (n !== DEPTH + 1) begin n_err++; $display("FAIL full_pushes: got %0d required %0d", n, DEPTH + 1); end
    n_cmp++; if (level !== 5'(DEPTH)) begin n_err++; $display("FAIL full_level: got %0d required %0d", level, DEPTH); end
    n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b required 0", cmd_ready); end
    n_cmp++; if (fsm_state !== WAIT) begin n_err++; $display("FAIL full_state: got %0d required %0d", fsm_state, WAIT); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL flush_level: got %0d required 0", level); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy: got %b required 0", busy); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready: got %b required 1", cmd_ready); end
    // a push coinciding with flush is dropped
    cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_addr = 5'h07; cmd_wdata = 8'h77; cmd_delay = '0; flush = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0; flush = 1'b0;
    n_cmp++; if (level !== 5'd0 || busy !== 1'b0) begin n_err++; $display("FAIL flush_push_drop: got level %0d busy %b required 0/0", level, busy); end
    repeat (110*CE_DIV) @(posedge clk);
    #1;
    n_cmp++; if (we_cnt !== we0) begin n_err++; $display("FAIL flush_no_write: got %0d pulses required 0", we_cnt - we0); end
  endtask

  task automatic test_reset_mid_wait();
    int we0; bit acc;
    we0 = we_cnt;
    push_cmd(1'b0, 5'h04, 8'h44, 50, acc);
    repeat (10*CE_DIV) @(posedge clk);
    #1;
    n_cmp++; if (fsm_state !== WAIT || busy !== 1'b1) begin n_err++; $display("FAIL midrst_waiting: got state %0d busy %b required %0d/1", fsm_state, busy, WAIT); end
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (sid_we !== 1'b0) begin n_err++; $display("FAIL midrst_we: got %b required 0", sid_we); end
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++; if (level !== 5'd0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin n_err++; $display("FAIL midrst_empty: got level %0d busy %b ready %b required 0/0/1", level, busy, cmd_ready); end
    repeat (60*CE_DIV) @(posedge clk);
    #1;
    n_cmp++; if (we_cnt !== we0) begin n_err++; $display("FAIL midrst_no_write: got %0d pulses required 0", we_cnt - we0); end
  endtask

`ifdef SID_PLAYER_SHADOW_EN
  task automatic test_shadow();
    int we0; bit acc, ok;
    we0 = we_cnt;
    push_cmd(1'b0, 5'h05, 8'h3C, 0, acc);
    wait_we(we0 + 1, 3*CE_DIV, ok);
    @(posedge clk); #1;
    shadow_addr = 5'h05; #1;
    n_cmp++; if (shadow_q !== 8'h3C) begin n_err++; $display("FAIL shadow_q: got %h required 3c", shadow_q); end
    shadow_addr = SID_OSC3; #1;
    n_cmp++; if (shadow_q !== 8'h00) begin n_err++; $display("FAIL shadow_q_high: got %h required 00", shadow_q); end
    test_read(5'h05, 8'h3C, "shadow_rd");
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_delay_pacing();
    pot_x = 8'hA5;
    test_read(SID_POTX, 8'hA5, "rd_potx");
    test_read(SID_ENV3, 8'h5A, "rd_env3");
`ifdef SID_PLAYER_SHADOW_EN
    test_read(5'h18, 8'h0F, "rd_wo");
    test_shadow();
`else
    test_read(5'h18, 8'h00, "rd_wo");
`endif
    test_full_flush();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
